// File: rtl/ei_axi4_slave_mem.sv
// AXI4 slave memory endpoint: independent write (AW/W/B) and read (AR/R) engines
// over a shared byte-strobed word array; FIXED/INCR/WRAP bursts with SLVERR reporting.
module ei_axi4_slave_mem #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDXW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    function automatic logic bad_burst(input logic [2:0] size, input logic [7:0] len,
                                       input logic [1:0] burst);
        bad_burst = (size > 3'(LSB)) ||
                    ((burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        in_range = (a >= BASE_ADDR) && (((a - BASE_ADDR) >> LSB) < ADDR_WIDTH'(MEM_DEPTH));
    endfunction

    function automatic logic [IDXW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        word_idx = IDXW'((a - BASE_ADDR) >> LSB);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] span;
        step = A_ONE << size;
        span = (ADDR_WIDTH'(len) + A_ONE) << size;
        case (burst)
            BURST_FIXED: next_addr = a;
            BURST_WRAP:  next_addr = (a & ~(span - A_ONE)) | ((a + step) & (span - A_ONE));
            default:     next_addr = (a & ~(step - A_ONE)) + step;
        endcase
    endfunction

    // write engine
    w_state_t              w_state, w_state_n;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len, w_cnt;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic                  w_bad, w_err;
    logic                  aw_fire, w_fire, w_final, w_beat_ok;

    assign aw_fire   = awvalid && awready;
    assign w_fire    = wvalid && wready;
    assign w_final   = (w_cnt == w_len);
    assign w_beat_ok = !w_bad && in_range(w_addr);
    assign bid       = w_id;
    assign bresp     = w_err ? RESP_SLVERR : RESP_OKAY;

    always_comb begin
        w_state_n = w_state;
        case (w_state)
            W_IDLE:  if (aw_fire) w_state_n = W_DATA;
            W_DATA:  if (w_fire && w_final) w_state_n = W_RESP;
            W_RESP:  if (bvalid && bready) w_state_n = W_IDLE;
            default: w_state_n = W_IDLE;
        endcase
    end

    // handshake flags are registered from the next state so they all read 0 right after reset
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
        end else begin
            w_state <= w_state_n;
            awready <= (w_state_n == W_IDLE);
            wready  <= (w_state_n == W_DATA);
            bvalid  <= (w_state_n == W_RESP);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_bad   <= 1'b0;
            w_err   <= 1'b0;
        end else if (aw_fire) begin
            w_id    <= awid;
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= awburst;
            w_cnt   <= '0;
            w_bad   <= bad_burst(awsize, awlen, awburst);
            w_err   <= bad_burst(awsize, awlen, awburst);
        end else if (w_fire) begin
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            w_cnt  <= w_cnt + 8'd1;
            if (!w_beat_ok || (wlast != w_final))
                w_err <= 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!areset && w_fire && w_beat_ok) begin
            for (int b = 0; b < BYTES; b++)
                if (wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    // read engine
    r_state_t              r_state, r_state_n;
    logic [ADDR_WIDTH-1:0] r_addr, r_addr_nx, rd_addr;
    logic [7:0]            r_len, r_cnt;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_bad, rd_bad, rd_ok;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  ar_fire, r_fire;

    assign ar_fire = arvalid && arready;
    assign r_fire  = rvalid && rready;

    // one read port: the AR address while idle, otherwise the following beat's address
    always_comb begin
        r_addr_nx = next_addr(r_addr, r_len, r_size, r_burst);
        if (r_state == R_IDLE) begin
            rd_addr = araddr;
            rd_bad  = bad_burst(arsize, arlen, arburst);
        end else begin
            rd_addr = r_addr_nx;
            rd_bad  = r_bad;
        end
        rd_ok   = !rd_bad && in_range(rd_addr);
        rd_word = rd_ok ? mem[word_idx(rd_addr)] : '0;
    end

    always_comb begin
        r_state_n = r_state;
        case (r_state)
            R_IDLE:  if (ar_fire) r_state_n = R_DATA;
            R_DATA:  if (r_fire && (r_cnt == r_len)) r_state_n = R_IDLE;
            default: r_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
        end else begin
            r_state <= r_state_n;
            arready <= (r_state_n == R_IDLE);
            rvalid  <= (r_state_n == R_DATA);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_bad   <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            rlast   <= 1'b0;
        end else if (ar_fire) begin
            r_addr  <= araddr;
            r_len   <= arlen;
            r_cnt   <= '0;
            r_size  <= arsize;
            r_burst <= arburst;
            r_bad   <= rd_bad;
            rid     <= arid;
            rdata   <= rd_word;
            rresp   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            rlast   <= (arlen == 8'd0);
        end else if (r_fire) begin
            if (r_cnt == r_len) begin
                rlast <= 1'b0;
            end else begin
                r_addr <= r_addr_nx;
                r_cnt  <= r_cnt + 8'd1;
                rdata  <= rd_word;
                rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                rlast  <= ((r_cnt + 8'd1) == r_len);
            end
        end
    end

endmodule

// File: tb/tb_ei_axi4_slave_mem.sv
// Scoreboard bench for ei_axi4_slave_mem: directed scenarios plus randomized bursts
// checked against a byte-level memory model with per-byte "known" tracking.
module tb_ei_axi4_slave_mem;
    localparam int DEPTH = 1024;
    localparam int BYTES = 4;
    localparam int unsigned BASE = 0;

    logic        aclk = 1'b0;
    logic        areset;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [3:0]  wstrb;

    ei_axi4_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4),
                        .MEM_DEPTH(DEPTH), .BASE_ADDR(32'(BASE))) dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    typedef struct { logic [3:0] id; logic [1:0] resp; } b_t;
    typedef struct { logic [3:0] id; logic [31:0] data; logic [31:0] mask; logic [1:0] resp; logic last; } r_t;

    b_t exp_b[$];
    r_t exp_r[$];
    logic [31:0] mdata [DEPTH];
    logic [3:0]  mknown[DEPTH];
    logic [31:0] wd[16];
    logic [3:0]  ws[16];

    int checks = 0;
    int errors = 0;
    int bmode = 0, rmode = 0, bhold = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // reference model, written from the address rules rather than as a register update
    function automatic int unsigned beat_addr(int unsigned start, int len, int size, int burst, int i);
        int unsigned n = 32'd1 << size;
        int unsigned t, base;
        case (burst)
            0: return start;
            2: begin
                t = (len + 1) * n;
                base = start - (start % t);
                return base + ((start - base + i * n) % t);
            end
            default: return (i == 0) ? start : (start - (start % n)) + i * n;
        endcase
    endfunction

    function automatic bit burst_bad(int size, int len, int burst);
        return ((1 << size) > BYTES) || (burst == 2 && !(len inside {1, 3, 7, 15}));
    endfunction

    function automatic bit in_mem(int unsigned a);
        return (a >= BASE) && ((a - BASE) / BYTES < DEPTH);
    endfunction

    task automatic wait_hs(input int which);
        bit ok = 0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge aclk);
            ok = (which == 0 && awready) || (which == 1 && wready) || (which == 2 && arready);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL handshake_timeout channel=%0d actual=0 required=1", which);
        end
        @(posedge aclk); #1;
    endtask

    task automatic do_write(input logic [3:0] id, input int unsigned addr, input int len,
                            input int size, input int burst, input int bad_last, input int abort_at);
        bit bad = burst_bad(size, len, burst);
        bit err = bad;
        int unsigned a, w;
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, len, size, burst, i);
            if (i == bad_last) err = 1;
            if (!bad && !in_mem(a)) err = 1;
            if (!bad && in_mem(a) && (abort_at < 0 || i < abort_at)) begin
                w = (a - BASE) / BYTES;
                for (int b = 0; b < BYTES; b++)
                    if (ws[i][b]) begin
                        mdata[w][8*b +: 8] = wd[i][8*b +: 8];
                        mknown[w][b] = 1'b1;
                    end
            end
        end
        if (abort_at < 0) exp_b.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
        awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
        awvalid = 1;
        wait_hs(0);
        awvalid = 0;
        for (int i = 0; i <= len; i++) begin
            if (i == abort_at) begin
                areset = 1;
                @(posedge aclk); #1;
                areset = 0;
                @(negedge aclk);
                chk("rst_awready", awready, 0);
                chk("rst_wready", wready, 0);
                chk("rst_bvalid", bvalid, 0);
                chk("rst_arready", arready, 0);
                chk("rst_rvalid", rvalid, 0);
                @(posedge aclk); #1;
                return;
            end
            wvalid = 1; wdata = wd[i]; wstrb = ws[i];
            wlast = (i == len) ^ (i == bad_last);
            wait_hs(1);
            wvalid = 0;
        end
    endtask

    task automatic do_read(input logic [3:0] id, input int unsigned addr, input int len,
                           input int size, input int burst);
        bit bad = burst_bad(size, len, burst);
        int unsigned a, w;
        r_t e;
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, len, size, burst, i);
            e.id = id; e.last = (i == len);
            if (bad || !in_mem(a)) begin
                e.data = 0; e.mask = '1; e.resp = 2'b10;
            end else begin
                w = (a - BASE) / BYTES;
                e.data = mdata[w]; e.resp = 2'b00;
                for (int b = 0; b < BYTES; b++) e.mask[8*b +: 8] = {8{mknown[w][b]}};
            end
            exp_r.push_back(e);
        end
        arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
        arvalid = 1;
        wait_hs(2);
        arvalid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 2000) begin
            @(negedge aclk); n++;
        end
        if (exp_b.size() != 0 || exp_r.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d/%0d pending required=0", exp_b.size(), exp_r.size());
            exp_b.delete(); exp_r.delete();
        end
        @(posedge aclk); #1;
    endtask

    always begin
        @(posedge aclk); #1;
        if (bhold > 0) begin
            bready = 0;
            if (bvalid) bhold--;
        end else begin
            bready = (bmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        case (rmode)
            1:       rready = 1'($urandom_range(0, 1));
            2:       rready = ~rready;
            default: rready = 1'b1;
        endcase
    end

    // monitors: sample mid-cycle, a valid&ready seen here completes on the next rising edge
    b_t be; r_t re;
    bit b_hold = 0, r_hold = 0;
    logic [5:0]  b_prev;
    logic [38:0] r_prev;
    always @(negedge aclk) begin
        if (b_hold) begin
            chk("b_hold_valid", bvalid, 1);
            chk("b_hold_stable", {bid, bresp}, b_prev);
        end
        if (bvalid && bready) begin
            b_hold = 0;
            if (exp_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected actual=bvalid required=none");
            end else begin
                be = exp_b.pop_front();
                chk("b_id", bid, be.id);
                chk("b_resp", bresp, be.resp);
            end
        end else if (bvalid) begin
            b_hold = 1; b_prev = {bid, bresp};
        end else b_hold = 0;

        if (r_hold) begin
            chk("r_hold_valid", rvalid, 1);
            chk("r_hold_stable", {rid, rdata, rresp, rlast}, r_prev);
        end
        if (rvalid && rready) begin
            r_hold = 0;
            if (exp_r.size() == 0) begin
                checks++; errors++;
                $display("FAIL r_unexpected actual=rvalid required=none");
            end else begin
                re = exp_r.pop_front();
                chk("r_id", rid, re.id);
                chk("r_data", rdata & re.mask, re.data & re.mask);
                chk("r_resp", rresp, re.resp);
                chk("r_last", rlast, re.last);
            end
        end else if (rvalid) begin
            r_hold = 1; r_prev = {rid, rdata, rresp, rlast};
        end else r_hold = 0;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int size, burst, len;
        int unsigned addr;
        for (int i = 0; i < DEPTH; i++) begin mdata[i] = 0; mknown[i] = 0; end
        areset = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
        wdata = 0; wstrb = 0; wlast = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("reset_outs", {awready, wready, bvalid, arready, rvalid, rlast}, 0);
        chk("reset_resp", {bresp, rresp}, 0);
        chk("reset_ids_data", {bid, rid, rdata}, 0);
        @(posedge aclk); #1; areset = 0;
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("idle_awready", awready, 1);
        chk("idle_arready", arready, 1);
        @(posedge aclk); #1;

        // INCR write then read back
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        do_write(4'd1, 32'h10, 3, 2, 1, -1, -1); drain();
        do_read(4'd2, 32'h10, 3, 2, 1); drain();
        // WRAP read
        do_read(4'd3, 32'h18, 3, 2, 2); drain();
        // byte strobes, FIXED burst
        wd[0] = 0; ws[0] = 4'hF; do_write(4'd4, 32'h40, 0, 2, 1, -1, -1); drain();
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101; do_write(4'd4, 32'h40, 0, 2, 1, -1, -1); drain();
        do_read(4'd5, 32'h40, 0, 2, 1); drain();
        wd[0] = 32'h1; wd[1] = 32'h2; wd[2] = 32'h3; ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
        do_write(4'd6, 32'h44, 2, 2, 0, -1, -1); drain();
        do_read(4'd7, 32'h44, 0, 2, 1); drain();
        // top of memory and oversize beats
        wd[0] = 32'hA1; wd[1] = 32'hA2; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(4'd8, 32'(DEPTH * BYTES - 4), 1, 2, 1, -1, -1); drain();
        do_read(4'd9, 32'(DEPTH * BYTES - 4), 1, 2, 1); drain();
        wd[0] = 32'h55; ws[0] = 4'hF; do_write(4'd10, 32'h80, 0, 2, 1, -1, -1); drain();
        wd[0] = 32'h99; do_write(4'd11, 32'h80, 0, 3, 1, -1, -1); drain();
        do_read(4'd12, 32'h80, 0, 2, 1); drain();
        // misplaced wlast, illegal WRAP length
        wd[0] = 32'hC0; wd[1] = 32'hC1; wd[2] = 32'hC2; ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
        do_write(4'd13, 32'h100, 2, 2, 1, 1, -1); drain();
        do_read(4'd14, 32'h100, 2, 2, 1); drain();
        do_read(4'd15, 32'h100, 2, 2, 2); drain();
        // backpressure on both channels concurrently
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        bhold = 5; rmode = 2;
        fork
            do_write(4'd2, 32'h200, 3, 2, 1, -1, -1);
            do_read(4'd3, 32'h10, 3, 2, 1);
        join
        drain(); rmode = 0;
        do_read(4'd4, 32'h200, 3, 2, 1); drain();
        // reset in the middle of a write burst
        for (int i = 0; i < 8; i++) begin wd[i] = 32'hD0 + i; ws[i] = 4'hF; end
        do_write(4'd7, 32'h300, 7, 2, 1, -1, 2);
        repeat (4) begin @(negedge aclk); chk("no_b_after_reset", bvalid, 0); end
        @(posedge aclk); #1;
        wd[0] = 32'hE0; wd[1] = 32'hE1;
        do_write(4'd8, 32'h300, 1, 2, 1, -1, -1); drain();
        do_read(4'd9, 32'h300, 7, 2, 1); drain();
        // randomized bursts
        bmode = 1; rmode = 1;
        for (int k = 0; k < 40; k++) begin
            size = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            burst = $urandom_range(0, 2);
            len = (burst == 2) ? (($urandom_range(0, 9) == 0) ? 2 : (2 << $urandom_range(0, 3)) - 1)
                               : $urandom_range(0, 7);
            addr = ($urandom_range(0, 7) == 0) ? $urandom_range(32'hFE0, 32'hFFF)
                                                : $urandom_range(32'h400, 32'h7FF);
            addr = addr & ~((32'd1 << size) - 1);
            for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            do_write(4'($urandom), addr, len, size, burst, -1, -1); drain();
            do_read(4'($urandom), addr, len, size, burst); drain();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
